// File: rtl/mul4_shift_add_ctrl_if.sv
// Operand handshake plus the round trip to the external 4-bit ripple adder.
// The slave modport is the multiplier controller; the master is the source/adder side.
interface mul4_shift_add_ctrl_if;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       busy;
  logic       done;
  logic [7:0] product;
  logic [3:0] add_a;
  logic [3:0] add_b;
  logic       add_cin;
  logic [3:0] add_sum;
  logic       add_cout;

  modport slave (
    input  start, a, b, add_sum, add_cout,
    output busy, done, product, add_a, add_b, add_cin
  );

  modport master (
    output start, a, b, add_sum, add_cout,
    input  busy, done, product, add_a, add_b, add_cin
  );
endinterface

// File: rtl/mul4_shift_add_ctrl.sv
// Sequential 4x4 unsigned shift-add multiplier controller driving an external ripple adder.
// Four CALC iterations build {ACC,Q}; adder operands are registered alongside the datapath state.
module mul4_shift_add_ctrl (
  input  logic                      clk,
  input  logic                      rst_n,
  mul4_shift_add_ctrl_if.slave      bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_r;
  logic [3:0] m_r;
  logic [3:0] q_r;
  logic [3:0] acc_r;
  logic [1:0] cnt_r;
  logic       busy_r;
  logic       done_r;
  logic [7:0] product_r;
  logic [3:0] add_a_r;
  logic [3:0] add_b_r;
  logic [3:0] acc_next_s;
  logic [3:0] q_next_s;

  assign acc_next_s  = {bus.add_cout, bus.add_sum[3:1]};
  assign q_next_s    = {bus.add_sum[0], q_r[3:1]};

  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.product = product_r;
  assign bus.add_a   = add_a_r;
  assign bus.add_b   = add_b_r;
  assign bus.add_cin = 1'b0;

  // Control FSM and datapath; add_a/add_b are preloaded with the operands of the next CALC cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      m_r       <= 4'h0;
      q_r       <= 4'h0;
      acc_r     <= 4'h0;
      cnt_r     <= 2'd0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      product_r <= 8'h00;
      add_a_r   <= 4'h0;
      add_b_r   <= 4'h0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r  <= 1'b0;
          add_a_r <= 4'h0;
          if (bus.start) begin
            m_r     <= bus.a;
            q_r     <= bus.b;
            acc_r   <= 4'h0;
            cnt_r   <= 2'd0;
            busy_r  <= 1'b1;
            add_b_r <= bus.b[0] ? bus.a : 4'h0;
            state_r <= CALC;
          end else begin
            busy_r  <= 1'b0;
            add_b_r <= 4'h0;
            state_r <= IDLE;
          end
        end
        CALC: begin
          acc_r <= acc_next_s;
          q_r   <= q_next_s;
          cnt_r <= cnt_r + 2'd1;
          if (cnt_r == 2'd3) begin
            product_r <= {acc_next_s, q_next_s};
            busy_r    <= 1'b0;
            done_r    <= 1'b1;
            add_a_r   <= 4'h0;
            add_b_r   <= 4'h0;
            state_r   <= DONE;
          end else begin
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
            add_a_r <= acc_next_s;
            // q_next_s[0] is q_r[1]: the multiplier bit examined in the following iteration
            add_b_r <= q_r[1] ? m_r : 4'h0;
            state_r <= CALC;
          end
        end
        DONE: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          add_a_r <= 4'h0;
          add_b_r <= 4'h0;
          state_r <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          add_a_r <= 4'h0;
          add_b_r <= 4'h0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul4_shift_add_ctrl.sv
// Scoreboard bench: stimulus pushes expected products, a negedge monitor checks done/product,
// busy length, adder operands, accept spacing and output exclusivity.
module tb_mul4_shift_add_ctrl;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] prod;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb_q[$];
  int   acc_cnt  = 0;
  int   done_cnt = 0;
  bit   held     = 1'b0;

  mul4_shift_add_ctrl_if bus ();

  mul4_shift_add_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench-side 4-bit ripple-carry adder
  always_comb begin
    logic c;
    c = bus.add_cin;
    bus.add_sum = 4'h0;
    for (int i = 0; i < 4; i++) begin
      bus.add_sum[i] = bus.add_a[i] ^ bus.add_b[i] ^ c;
      c = (bus.add_a[i] & bus.add_b[i]) | (c & (bus.add_a[i] ^ bus.add_b[i]));
    end
    bus.add_cout = c;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares DUT outputs against the scoreboard on every falling edge
  initial begin : monitor
    int   busy_run;
    int   cyc;
    int   last_acc;
    logic prev_busy;
    logic prev_done;
    logic [3:0] exp_b;
    exp_t e;
    busy_run  = 0;
    cyc       = 0;
    last_acc  = -1;
    prev_busy = 1'b0;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        busy_run  = 0;
        prev_busy = 1'b0;
        prev_done = 1'b0;
        last_acc  = -1;
      end else begin
        chk("busy_done_excl", {31'd0, bus.busy & bus.done}, 32'd0);
        chk("add_cin", {31'd0, bus.add_cin}, 32'd0);
        if (bus.busy && !prev_busy) begin
          acc_cnt++;
          if (held && last_acc >= 0) chk("accept_spacing", cyc - last_acc, 32'd6);
          last_acc = cyc;
        end
        if (!held) last_acc = -1;
        if (bus.busy) begin
          if (sb_q.size() == 0) begin
            chk("busy_without_request", 32'd1, 32'd0);
          end else if (busy_run < 4) begin
            e = sb_q[0];
            exp_b = e.b[busy_run[1:0]] ? e.a : 4'h0;
            chk("add_b_calc", {28'd0, bus.add_b}, {28'd0, exp_b});
          end
          busy_run++;
        end else begin
          chk("add_a_idle", {28'd0, bus.add_a}, 32'd0);
          chk("add_b_idle", {28'd0, bus.add_b}, 32'd0);
        end
        if (bus.done) begin
          done_cnt++;
          chk("done_single_pulse", {31'd0, prev_done}, 32'd0);
          chk("busy_cycles", busy_run, 32'd4);
          busy_run = 0;
          if (sb_q.size() == 0) begin
            chk("done_without_request", 32'd1, 32'd0);
          end else begin
            e = sb_q.pop_front();
            chk("product", {24'd0, bus.product}, {24'd0, e.prod});
          end
        end
        prev_busy = bus.busy;
        prev_done = bus.done;
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while ((bus.busy || bus.done) && n < 20);
    if (bus.busy || bus.done) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic do_mul(input logic [3:0] a, input logic [3:0] b, input logic [7:0] prod,
                        input bit perturb);
    wait_idle();
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    sb_q.push_back('{a, b, prod});
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    if (perturb) begin
      bus.a = ~a;
      bus.b = ~b;
    end
  endtask

  initial begin : stim
    int n;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = 4'h0;
    bus.b     = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_product", {24'd0, bus.product}, 32'h00);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_add_a", {28'd0, bus.add_a}, 32'd0);
    chk("rst_add_b", {28'd0, bus.add_b}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_mul(4'hF, 4'hF, 8'hE1, 1'b0);
    do_mul(4'hD, 4'hB, 8'h8F, 1'b0);
    do_mul(4'h0, 4'h9, 8'h00, 1'b0);
    do_mul(4'h7, 4'h0, 8'h00, 1'b0);
    do_mul(4'h6, 4'h5, 8'h1E, 1'b1);

    // start held high: three accepts six cycles apart
    wait_idle();
    bus.a     = 4'h3;
    bus.b     = 4'h5;
    bus.start = 1'b1;
    held      = 1'b1;
    for (int i = 0; i < 3; i++) sb_q.push_back('{4'h3, 4'h5, 8'h0F});
    repeat (13) @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(negedge clk);
    #1;
    held = 1'b0;

    // reset in the second CALC cycle discards the multiply
    do_mul(4'h2, 4'h3, 8'h06, 1'b0);
    do_mul(4'hF, 4'hF, 8'hE1, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_product", {24'd0, bus.product}, 32'h00);
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_done", {31'd0, bus.done}, 32'd0);
    chk("abort_add_a", {28'd0, bus.add_a}, 32'd0);
    chk("abort_add_b", {28'd0, bus.add_b}, 32'd0);
    sb_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_mul(4'h9, 4'h9, 8'h51, 1'b0);

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        do_mul(a[3:0], b[3:0], 8'(a * b), 1'b0);
      end
    end

    n = 0;
    while (sb_q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    chk("scoreboard_drained", sb_q.size(), 32'd0);
    repeat (2) @(posedge clk);
    chk("done_vs_accept", done_cnt, acc_cnt - 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mul4_shift_add_ctrl.md
# mul4_shift_add_ctrl

Sequential 4x4 unsigned shift-add multiplier controller that sits directly upstream and downstream of the 4-bit ripple adder. It drives the adder's operand and carry-in inputs. It captures the adder's sum and carry-out every cycle. It assembles an 8-bit product over four iterations. A start/busy/done handshake isolates the operand source from the multi-cycle computation.

## Interface
Parameters: none. Width is fixed at 4-bit operands and an 8-bit product to match the adder.
- clk  input  1  single clock; all state updates on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request to begin a multiply; sampled only in IDLE
- a  input  4  multiplicand; captured on the accepting edge
- b  input  4  multiplier; captured on the accepting edge
- busy  output  1  high while in CALC
- done  output  1  single-cycle pulse; product valid and stable
- product  output  8  registered result; holds until the next completion
- add_a  output  4  adder operand A (accumulator)
- add_b  output  4  adder operand B (gated multiplicand)
- add_cin  output  1  adder carry-in; tied to 0
- add_sum  input  4  adder Sum, combinational return
- add_cout  input  1  adder Cout, combinational return

## Operation
- Internal registers:
  - M[3:0] holds the multiplicand.
  - Q[3:0] holds the multiplier and shifts right.
  - ACC[3:0] is the upper partial product.
  - cnt[1:0] is the iteration counter.
  - state is one of IDLE, CALC, DONE.
- IDLE:
  - busy=0, done=0.
  - add_a=0, add_b=0.
  - If start=1 at an edge: M<=a, Q<=b, ACC<=0, cnt<=0, state<=CALC.
- CALC:
  - busy=1.
  - add_a=ACC. add_b = Q[0] ? M : 4'h0. add_cin=0.
  - Each edge: ACC <= {add_cout, add_sum[3:1]}; Q <= {add_sum[0], Q[3:1]}; cnt <= cnt+1.
  - At the edge where cnt==3: product <= {add_cout, add_sum[3:1], add_sum[0], Q[3:1]}, i.e. the post-shift {ACC,Q}. Then state<=DONE.
- DONE:
  - done=1, busy=0, adder operands driven 0.
  - Next edge: state<=IDLE unconditionally.
- Arithmetic rules:
  - All arithmetic is unsigned.
  - The 5-bit {add_cout, add_sum} holds ACC+M without loss.
  - The final product is exact for all 256 operand pairs (max 15*15=225=8'hE1).
- start is ignored in CALC and DONE. It is not queued. The source must hold or re-assert it in IDLE.
- a and b are don't-care except on the accepting edge. Changes during CALC have no effect.
- Illegal or unreachable state encodings return to IDLE on the next edge.

## Timing
- Reset (rst_n=0, asynchronous, any state):
  - state=IDLE, busy=0, done=0, product=8'h00.
  - M, Q, ACC, cnt all cleared.
  - add_a=0, add_b=0, add_cin=0.
  - An in-flight multiply is discarded and product is not updated.
  - Release is synchronous in effect: the first accepting edge is the first edge with rst_n=1.
- Latency, with start accepted at edge k:
  - busy is high in cycles k+1 through k+4 (four CALC cycles).
  - product updates at edge k+4.
  - done is high for exactly one cycle, k+4 to k+5.
  - Earliest next accept is edge k+6 (start asserted in IDLE after done).
- Throughput: one multiply per 6 cycles.
- Adder path: add_a/add_b → add_sum/add_cout is a single combinational round trip within one clk period. No registering inside the adder path.
- product changes only at the completion edge. It is stable from done until the next completion or reset.

## Test plan
- Reset then a=4'hF, b=4'hF, start for one cycle → busy high 4 cycles, done pulse 1 cycle, product=8'hE1; add_b toggles between 4'hF and 4'h0 per Q[0].
- a=4'hD, b=4'hB → product=8'h8F (143); then a=4'h0, b=4'h9 → product=8'h00; then a=4'h7, b=4'h0 → 8'h00. Check add_b=0 every CALC cycle for b=0.
- start held high continuously with a=3, b=5 → product=8'h0F. Accepts occur exactly 6 cycles apart; start during CALC/DONE causes no restart. Changing a/b mid-CALC does not alter the result.
- Complete a=2, b=3 (product=8'h06). Start a=4'hF, b=4'hF, and assert rst_n=0 in the 2nd CALC cycle → all outputs go to reset values immediately, with product=8'h00. After release, a fresh 9*9 gives 8'h51.
- Exhaustive sweep of all 256 (a,b) pairs through the real ripple adder → product == a*b every time. done count equals start-accept count. busy and done are never high together.
